// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage with a valid/ready handshake on both sides.
// Each accepted instruction is decoded combinationally and stored in a small
// in-order buffer. The decoded entry appears on out_* one cycle after acceptance.
//   clk, rst       : rising-edge clock and asynchronous active-high reset
//   flush          : synchronous; empties the buffer and drops a same-cycle input
//   in_valid/ready : input handshake; in_instr is the raw word, in_pc is its PC
//   out_valid/ready: output handshake for the head entry
//   out_*          : decoded fields of the head entry (0 while in reset)
// Parameters:
//   XLEN : immediate and PC width; only 32 or 64 are supported
//   SKID : 1 = 2-entry buffer with registered in_ready
//          0 = single output register with in_ready = !out_valid | out_ready
module decode_stage #(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_fn3,
  output logic            out_fn7_5,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      fn3;
    logic            fn7_5;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } dec_t;

  // All immediates are first formed as 32-bit values, then sign-extended to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [63:0] w;
    w = {{32{v[31]}}, v};
    return w[XLEN-1:0];
  endfunction

  // ---------------- combinational decode ----------------
  dec_t       dec;
  logic [6:0] op;
  logic [2:0] f3;
  logic       ill;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.opcode = op;
    ill        = 1'b0;
    case (op)
      OP_R: begin
        dec.rd = in_instr[11:7]; dec.fn3 = f3;
        dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20];
        dec.fn7_5 = in_instr[30];
      end
      OP_IALU, OP_LOAD, OP_JALR: begin
        dec.rd = in_instr[11:7]; dec.fn3 = f3; dec.rs1 = in_instr[19:15];
        dec.imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        if (op == OP_LOAD) ill = (f3 == 3'd3) || (f3 >= 3'd6);
        if (op == OP_JALR) ill = (f3 != 3'd0);
      end
      OP_STORE: begin
        dec.fn3 = f3; dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20];
        dec.imm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
        ill = (f3 >= 3'd3);
      end
      OP_BR: begin
        dec.fn3 = f3; dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20];
        dec.imm = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0});
        ill = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OP_JAL: begin
        dec.rd = in_instr[11:7];
        dec.imm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0});
      end
      OP_LUI, OP_AUIPC: begin
        dec.rd = in_instr[11:7];
        dec.imm = sext32({in_instr[31:12], 12'b0});
      end
      default: ill = 1'b1;
    endcase
    // Illegal encodings carry only opcode and PC so downstream never sees junk.
    if (ill) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.opcode  = op;
      dec.illegal = 1'b1;
    end
  end

  // ---------------- in-order buffer ----------------
  // ent0 is always the head; ent1 holds a second entry only in SKID mode.
  dec_t       ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push, pop;

  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;  // a same-cycle push is dropped
    end else begin
      case ({push, pop})
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever remains.
          if (cnt_q == 2'd2) begin
            ent0_d = ent1_q;
            ent1_d = dec;
          end else begin
            ent0_d = dec;
          end
        end
        2'b10: begin
          if (cnt_q == 2'd0) ent0_d = dec;
          else               ent1_d = dec;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      // Registered ready: it looks at next-cycle occupancy, so the 2-entry
      // buffer absorbs the one extra beat a registered ready lets through.
      logic in_ready_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready_q <= 1'b0;
        else     in_ready_q <= (cnt_d < 2'd2);
      end
      assign in_ready = in_ready_q;
    end else begin : g_reg
      assign in_ready = ~rst & (~out_valid | out_ready);
    end
  endgenerate

  assign out_pc      = ent0_q.pc;
  assign out_opcode  = ent0_q.opcode;
  assign out_rd      = ent0_q.rd;
  assign out_rs1     = ent0_q.rs1;
  assign out_rs2     = ent0_q.rs2;
  assign out_fn3     = ent0_q.fn3;
  assign out_fn7_5   = ent0_q.fn7_5;
  assign out_imm     = ent0_q.imm;
  assign out_illegal = ent0_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: XLEN=32/SKID=1 (a_*), XLEN=64/SKID=1 (b_*)
// sharing one stimulus stream, and XLEN=32/SKID=0 (c_*) with its own handshake.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, in_valid0, out_ready0;
  logic [31:0] in_instr, in_pc;
  int          n_chk = 0, n_fail = 0;

  logic        a_in_ready, a_valid, a_f7, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [6:0]  a_op;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_fn3;

  logic        b_in_ready, b_valid, b_f7, b_ill;
  logic [63:0] b_pc, b_imm;
  logic [6:0]  b_op;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_fn3;

  logic        c_in_ready, c_valid, c_f7, c_ill;
  logic [31:0] c_pc, c_imm;
  logic [6:0]  c_op;
  logic [4:0]  c_rd, c_rs1, c_rs2;
  logic [2:0]  c_fn3;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SKID(1'b1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_opcode(a_op), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_fn3(a_fn3), .out_fn7_5(a_f7), .out_imm(a_imm), .out_illegal(a_ill));

  decode_stage #(.XLEN(64), .SKID(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc({32'h0, in_pc}), .out_valid(b_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_opcode(b_op), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_fn3(b_fn3), .out_fn7_5(b_f7), .out_imm(b_imm), .out_illegal(b_ill));

  decode_stage #(.XLEN(32), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid0), .in_ready(c_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(c_valid), .out_ready(out_ready0),
    .out_pc(c_pc), .out_opcode(c_op), .out_rd(c_rd), .out_rs1(c_rs1), .out_rs2(c_rs2),
    .out_fn3(c_fn3), .out_fn7_5(c_f7), .out_imm(c_imm), .out_illegal(c_ill));

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b0; in_instr = 32'hFFF10093; in_pc = 32'h44;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", a_valid); end
    n_chk++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", a_in_ready); end
    n_chk++; if (c_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_skid0: got %b want 0", c_in_ready); end
    n_chk++; if ({a_pc, a_imm, a_op, a_rd, a_rs1, a_rs2, a_fn3, a_f7, a_ill} !== '0) begin n_fail++; $display("FAIL rst_data32: got nonzero pc=%h imm=%h", a_pc, a_imm); end
    n_chk++; if ({b_pc, b_imm} !== 128'h0) begin n_fail++; $display("FAIL rst_data64: got pc=%h imm=%h want 0", b_pc, b_imm); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", a_in_ready); end
    n_chk++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_valid: got %b want 0", a_valid); end
  endtask

  task automatic test_decode();
    logic [31:0] v_ins [13] = '{32'hFFF10093, 32'hFE208EE3, 32'hFE112E23, 32'h402081B3,
                                32'h008000EF, 32'h800000B7, 32'h0000007F, 32'hFFF090E7,
                                32'h00003083, 32'h00001067, 32'h00002063, 32'hFFF12083,
                                32'h12345297};
    logic [4:0]  v_rd  [13] = '{1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 1, 5};
    logic [4:0]  v_rs1 [13] = '{2, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0};
    logic [4:0]  v_rs2 [13] = '{0, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [2:0]  v_fn3 [13] = '{0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0};
    logic        v_f7  [13] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic        v_ill [13] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    logic [31:0] v_imm [13] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,
                                32'h8, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'hFFFFFFFF, 32'h12345000};
    logic [31:0] ins, pc;
    logic [63:0] imm64;
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      ins = v_ins[i]; pc = 32'h1000 + 32'(i) * 32'd4;
      imm64 = {{32{v_imm[i][31]}}, v_imm[i]};
      push(ins, pc);
      n_chk++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL dec_valid[%0d]: got %b want 1", i, a_valid); end
      n_chk++; if (a_pc !== pc) begin n_fail++; $display("FAIL dec_pc[%0d]: got %h want %h", i, a_pc, pc); end
      n_chk++; if (a_op !== ins[6:0]) begin n_fail++; $display("FAIL dec_op[%0d]: got %h want %h", i, a_op, ins[6:0]); end
      n_chk++; if ({a_rd, a_rs1, a_rs2} !== {v_rd[i], v_rs1[i], v_rs2[i]}) begin n_fail++;
        $display("FAIL dec_regs[%0d]: got rd=%0d rs1=%0d rs2=%0d want %0d %0d %0d", i, a_rd, a_rs1, a_rs2, v_rd[i], v_rs1[i], v_rs2[i]); end
      n_chk++; if ({a_fn3, a_f7} !== {v_fn3[i], v_f7[i]}) begin n_fail++;
        $display("FAIL dec_fn[%0d]: got fn3=%0d f7=%b want %0d %b", i, a_fn3, a_f7, v_fn3[i], v_f7[i]); end
      n_chk++; if (a_imm !== v_imm[i]) begin n_fail++; $display("FAIL dec_imm[%0d]: got %h want %h", i, a_imm, v_imm[i]); end
      n_chk++; if (a_ill !== v_ill[i]) begin n_fail++; $display("FAIL dec_ill[%0d]: got %b want %b", i, a_ill, v_ill[i]); end
      n_chk++; if (b_imm !== imm64) begin n_fail++; $display("FAIL dec_imm64[%0d]: got %h want %h", i, b_imm, imm64); end
      n_chk++; if ({b_rd, b_ill} !== {v_rd[i], v_ill[i]}) begin n_fail++; $display("FAIL dec_64[%0d]: got rd=%0d ill=%b", i, b_rd, b_ill); end
    end
    @(posedge clk); #1;
    n_chk++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL dec_drain: got %b want 0", a_valid); end
  endtask

  task automatic test_lui64();
    out_ready = 1'b0;
    push(32'h800000B7, 32'h2000);
    n_chk++; if (b_imm !== 64'hFFFFFFFF80000000) begin n_fail++; $display("FAIL lui64_neg: got %h want ffffffff80000000", b_imm); end
    n_chk++; if (b_pc !== 64'h2000) begin n_fail++; $display("FAIL lui64_pc: got %h want 2000", b_pc); end
    out_ready = 1'b1;
    push(32'h123452B7, 32'h2004);
    n_chk++; if (b_imm !== 64'h0000000012345000) begin n_fail++; $display("FAIL lui64_pos: got %h want 12345000", b_imm); end
    n_chk++; if (b_rd !== 5'd5) begin n_fail++; $display("FAIL lui64_rd: got %0d want 5", b_rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h100;
    @(posedge clk); #1; in_pc = 32'h104;
    @(posedge clk); #1;
    n_chk++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b want 0", a_in_ready); end
    in_pc = 32'h108;
    @(posedge clk); #1;
    n_chk++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_third_blocked: got %b want 0", a_in_ready); end
    n_chk++; if ({a_valid, a_pc} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL b2b_stall_hold: got v=%b pc=%h want 1 100", a_valid, a_pc); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (a_pc !== 32'h104) begin n_fail++; $display("FAIL b2b_second: got %h want 104", a_pc); end
    n_chk++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_back: got %b want 1", a_in_ready); end
    @(posedge clk); #1;
    n_chk++; if (a_pc !== 32'h108) begin n_fail++; $display("FAIL b2b_third: got %h want 108", a_pc); end
    for (int k = 0; k < 4; k++) begin
      in_pc = 32'h10C + 32'(k) * 32'd4;
      @(posedge clk); #1;
      n_chk++; if ({a_valid, a_pc, a_in_ready} !== {1'b1, 32'h10C + 32'(k) * 32'd4, 1'b1}) begin n_fail++;
        $display("FAIL b2b_stream[%0d]: got v=%b pc=%h rdy=%b", k, a_valid, a_pc, a_in_ready); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", a_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push(32'hFFF10093, 32'h200);
    push(32'hFFF10093, 32'h204);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h208;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_chk++; if ({a_valid, a_in_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_full: got v=%b rdy=%b want 0 1", a_valid, a_in_ready); end
    @(posedge clk); #1;
    n_chk++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %b want 0", a_valid); end
    push(32'hFFF10093, 32'h20C);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h210;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL flush_prio: got %b want 0", a_valid); end
    push(32'hFFF10093, 32'h300);
    n_chk++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL mid_rst_pre: got %b want 1", a_valid); end
    rst = 1'b1; #1;
    n_chk++; if ({a_valid, a_in_ready, a_pc, a_rd} !== '0) begin n_fail++;
      $display("FAIL mid_rst: got v=%b rdy=%b pc=%h rd=%0d want 0", a_valid, a_in_ready, a_pc, a_rd); end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    n_chk++; if ({a_valid, a_in_ready} !== 2'b01) begin n_fail++; $display("FAIL mid_rst_release: got v=%b rdy=%b want 0 1", a_valid, a_in_ready); end
  endtask

  task automatic test_skid0();
    out_ready0 = 1'b0; in_valid0 = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h400; #1;
    n_chk++; if (c_in_ready !== 1'b1) begin n_fail++; $display("FAIL s0_empty_ready: got %b want 1", c_in_ready); end
    @(posedge clk); #1; in_valid0 = 1'b0;
    n_chk++; if ({c_valid, c_in_ready} !== 2'b10) begin n_fail++; $display("FAIL s0_held: got v=%b rdy=%b want 1 0", c_valid, c_in_ready); end
    n_chk++; if ({c_rd, c_rs1, c_imm} !== {5'd1, 5'd2, 32'hFFFFFFFF}) begin n_fail++; $display("FAIL s0_dec: got rd=%0d rs1=%0d imm=%h", c_rd, c_rs1, c_imm); end
    @(posedge clk); #1;
    n_chk++; if (c_pc !== 32'h400) begin n_fail++; $display("FAIL s0_stable: got %h want 400", c_pc); end
    out_ready0 = 1'b1; #1;
    n_chk++; if (c_in_ready !== 1'b1) begin n_fail++; $display("FAIL s0_pass_ready: got %b want 1", c_in_ready); end
    in_valid0 = 1'b1; in_pc = 32'h404;
    @(posedge clk); #1; in_valid0 = 1'b0;
    n_chk++; if ({c_valid, c_pc} !== {1'b1, 32'h404}) begin n_fail++; $display("FAIL s0_replace: got v=%b pc=%h want 1 404", c_valid, c_pc); end
    @(posedge clk); #1;
    n_chk++; if (c_valid !== 1'b0) begin n_fail++; $display("FAIL s0_drain: got %b want 0", c_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_lui64();
    test_back_to_back();
    test_flush();
    test_skid0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, immediate and PC width; legal values 32 and 64 only.
REQ-002 Parameter SKID, default 1; 1 selects a 2-entry buffer with registered in_ready, 0 selects a single output register.
REQ-003 clk  input  1  sole clock; all state on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous; discards all held entries.
REQ-006 in_valid  input  1  in_instr/in_pc are valid.
REQ-007 in_ready  output  1  stage can accept an instruction this cycle.
REQ-008 in_instr  input  32  raw RV32I instruction word.
REQ-009 in_pc  input  XLEN  PC of in_instr.
REQ-010 out_valid  output  1  decoded entry present on the out_* ports.
REQ-011 out_ready  input  1  consumer accepts the entry this cycle.
REQ-012 out_pc  output  XLEN  PC of the decoded entry.
REQ-013 out_opcode  output  7  instr[6:0].
REQ-014 out_rd, out_rs1, out_rs2  output  5 each  register indices.
REQ-015 out_fn3  output  3  instr[14:12].
REQ-016 out_fn7_5  output  1  instr[30].
REQ-017 out_imm  output  XLEN  fully formed, sign-extended immediate.
REQ-018 out_illegal  output  1  unsupported or malformed encoding.

Function
REQ-019 Each accepted instruction SHALL be decoded combinationally and stored in a buffer entry; latency from acceptance to out_valid SHALL be exactly 1 cycle.
REQ-020 A transfer SHALL occur on in_valid&in_ready at the input and on out_valid&out_ready at the output; entries SHALL leave in acceptance order.
REQ-021 With SKID=1, in_ready SHALL be a registered signal, high when fewer than 2 entries are held; full throughput (1 per cycle) SHALL be sustained while out_ready=1.
REQ-022 With SKID=0, in_ready SHALL equal (!out_valid | out_ready).
REQ-023 Field extraction per opcode:
- R (0110011): rd, fn3, rs1, rs2, fn7_5.
- I-ALU (0010011), load (0000011), JALR (1100111): rd, fn3, rs1.
- store (0100011) and branch (1100011): fn3, rs1, rs2.
- JAL (1101111), LUI (0110111), AUIPC (0010111): rd.
- All fields not listed SHALL be 0.
REQ-024 out_imm SHALL be sign-extended from instr[31] to XLEN:
- I/load/JALR: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- U: {instr[31:12], 12'b0}.
- R: 0.
REQ-025 out_illegal SHALL be 1 when the opcode is none of the nine listed, or JALR has fn3!=000, or branch fn3 is 010/011, or load fn3 is 011/110/111, or store fn3>=011; when illegal, all fields and out_imm SHALL be 0 except out_opcode and out_pc.
REQ-026 Simultaneous input and output transfer with 2 entries held SHALL NOT occur (in_ready=0); with 1 entry held it SHALL leave occupancy at 1.
REQ-027 flush SHALL empty the buffer at the next edge, taking priority over a same-cycle input transfer (the instruction is dropped); in_ready SHALL be 1 in the following cycle.
REQ-028 Outputs SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-029 While rst=1: occupancy 0, out_valid=0, in_ready=0, and all out_* data ports 0.
REQ-030 in_ready SHALL rise in the first cycle after rst deasserts; reset asserted mid-stream SHALL discard all held entries with no partial output.

Verification
REQ-031 XLEN=32: 0xFFF10093 (addi x1,x2,-1) -> rd=1, rs1=2, fn3=0, imm=0xFFFFFFFF, illegal=0, one cycle after acceptance.
REQ-032 XLEN=32: 0xFE208EE3 (beq x1,x2,-4) -> rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC.
REQ-033 XLEN=64: 0x800000B7 (lui x1,0x80000) -> rd=1, imm=0xFFFFFFFF80000000; 0x123452B7 -> rd=5, imm=0x0000000012345000.
REQ-034 0x0000007F and 0x00001067 (JALR fn3=001) -> illegal=1, rd/rs1/imm=0, opcode passed through.
REQ-035 SKID=1, out_ready=0, three back-to-back valid inputs -> first two accepted, in_ready=0 on the third; out_ready=1 -> all three delivered in order, then throughput of 1 per cycle.
REQ-036 flush asserted together with in_valid while 2 entries are held -> out_valid=0 next cycle, the instruction is dropped, in_ready=1; rst pulse mid-stream -> out_valid=0 immediately.
